// File: rtl/plic_core_mt_if.sv
// Signal bundle between the PLIC register front-end (master) and plic_core_mt (slave).
// Field packing: source i at [i*W +: W], target t at [t*W +: W] or [t*NUM_IRQ + i] for enables.
interface plic_core_mt_if #(
    parameter int NUM_IRQ    = 32,
    parameter int NUM_TGT    = 2,
    parameter int PRIO_WIDTH = 3,
    parameter int ID_WIDTH   = $clog2(NUM_IRQ)
);
    logic [NUM_IRQ-1:0]            irq_i;
    logic [NUM_IRQ-1:0]            trig_mode_i;
    logic [NUM_IRQ*PRIO_WIDTH-1:0] prio_i;
    logic [NUM_TGT*NUM_IRQ-1:0]    ie_i;
    logic [NUM_TGT*PRIO_WIDTH-1:0] thold_i;
    logic [NUM_TGT-1:0]            claim_i;
    logic [NUM_TGT-1:0]            comp_i;
    logic [NUM_TGT*ID_WIDTH-1:0]   comp_id_i;
    logic [NUM_IRQ-1:0]            ip_o;
    logic [NUM_TGT*ID_WIDTH-1:0]   id_o;
    logic [NUM_TGT-1:0]            irq_o;

    modport master (
        output irq_i, trig_mode_i, prio_i, ie_i, thold_i, claim_i, comp_i, comp_id_i,
        input  ip_o, id_o, irq_o
    );

    modport slave (
        input  irq_i, trig_mode_i, prio_i, ie_i, thold_i, claim_i, comp_i, comp_id_i,
        output ip_o, id_o, irq_o
    );
endinterface

// File: rtl/plic_core_mt.sv
// Multi-target PLIC core: per-source level/edge gateways, pending/in-flight state, per-target arbitration.
// Define PLIC_EDGE_CNT_EN to count edges seen while pending/in-flight instead of keeping a one-deep flag.
module plic_core_mt #(
    parameter int NUM_IRQ        = 32,
    parameter int NUM_TGT        = 2,
    parameter int PRIO_WIDTH     = 3,
    parameter int ID_WIDTH       = $clog2(NUM_IRQ),
    parameter int EDGE_CNT_WIDTH = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    plic_core_mt_if.slave bus
);

    // The one-deep flag is the same saturating counter capped at 1, and pending-time edges are not counted.
`ifdef PLIC_EDGE_CNT_EN
    localparam logic [EDGE_CNT_WIDTH-1:0] CNT_MAX     = '1;
    localparam bit                        CNT_ON_PEND = 1'b1;
`else
    localparam logic [EDGE_CNT_WIDTH-1:0] CNT_MAX     = EDGE_CNT_WIDTH'(1);
    localparam bit                        CNT_ON_PEND = 1'b0;
`endif

    logic [NUM_IRQ-1:0]        ip_q, ip_d;
    logic [NUM_IRQ-1:0]        inflight_q, inflight_d;
    logic [NUM_IRQ-1:0]        irq_prev_q;
    logic [EDGE_CNT_WIDTH-1:0] cnt_q [NUM_IRQ];
    logic [EDGE_CNT_WIDTH-1:0] cnt_d [NUM_IRQ];
    logic [ID_WIDTH-1:0]       best_id_q [NUM_TGT];
    logic [ID_WIDTH-1:0]       best_id_d [NUM_TGT];
    logic [NUM_TGT-1:0]        irq_out_q, irq_out_d;

    logic [NUM_TGT-1:0]          claim_win;
    logic [NUM_IRQ-1:0]          claimed;
    logic [NUM_IRQ-1:0]          completed;
    logic [NUM_TGT*ID_WIDTH-1:0] id_o_c;

    // Claim race resolution and per-source claim/complete decode.
    always_comb begin
        claim_win = '0;
        claimed   = '0;
        completed = '0;
        id_o_c    = '0;
        for (int t = 0; t < NUM_TGT; t++) begin
            claim_win[t] = bus.claim_i[t] && (best_id_q[t] != '0);
            for (int u = 0; u < t; u++) begin
                if (bus.claim_i[u] && (best_id_q[u] == best_id_q[t])) begin
                    claim_win[t] = 1'b0;
                end
            end
            id_o_c[t*ID_WIDTH +: ID_WIDTH] = (bus.claim_i[t] && !claim_win[t]) ? '0 : best_id_q[t];
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (claim_win[t] && (best_id_q[t] == ID_WIDTH'(i))) begin
                    claimed[i] = 1'b1;
                end
                if (bus.comp_i[t] && (bus.comp_id_i[t*ID_WIDTH +: ID_WIDTH] == ID_WIDTH'(i))
                        && bus.ie_i[t*NUM_IRQ + i] && inflight_q[i]) begin
                    completed[i] = 1'b1;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IRQ; gi++) begin : g_src
            localparam bit VALID = (gi != 0);
            logic                      rise;
            logic                      busy;
            logic                      repend;
            logic                      bump;
            logic                      ip_set;
            logic [EDGE_CNT_WIDTH-1:0] cnt_dec;

            assign rise    = bus.irq_i[gi] & ~irq_prev_q[gi];
            // In-flight as seen after this edge: completes retire the old state, claims set it afresh.
            assign busy    = (inflight_q[gi] & ~completed[gi]) | claimed[gi];
            assign repend  = completed[gi] & ~claimed[gi] & (cnt_q[gi] != '0);
            assign cnt_dec = repend ? (cnt_q[gi] - EDGE_CNT_WIDTH'(1)) : cnt_q[gi];
            assign bump    = bus.trig_mode_i[gi] & rise & (busy | (CNT_ON_PEND & ip_q[gi]));
            assign ip_set  = bus.trig_mode_i[gi] ? (rise & ~busy & ~ip_q[gi])
                                                 : (bus.irq_i[gi] & ~busy & ~ip_q[gi]);

            assign ip_d[gi]       = VALID & ((ip_q[gi] & ~claimed[gi]) | ip_set | repend);
            assign inflight_d[gi] = VALID & busy;
            assign cnt_d[gi]      = !VALID ? '0
                                  : (bump && (cnt_dec != CNT_MAX)) ? (cnt_dec + EDGE_CNT_WIDTH'(1))
                                  : cnt_dec;
        end
    endgenerate

    // Highest priority wins; the strict compare keeps the lowest ID on ties.
    always_comb begin
        logic [PRIO_WIDTH-1:0] best_p;
        logic [PRIO_WIDTH-1:0] p;
        best_p    = '0;
        p         = '0;
        irq_out_d = '0;
        for (int t = 0; t < NUM_TGT; t++) begin
            best_id_d[t] = '0;
            best_p       = '0;
            for (int i = 0; i < NUM_IRQ; i++) begin
                p = bus.prio_i[i*PRIO_WIDTH +: PRIO_WIDTH];
                if (ip_q[i] && bus.ie_i[t*NUM_IRQ + i]
                        && (p > bus.thold_i[t*PRIO_WIDTH +: PRIO_WIDTH]) && (p > best_p)) begin
                    best_p       = p;
                    best_id_d[t] = ID_WIDTH'(i);
                end
            end
            irq_out_d[t] = (best_id_d[t] != '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ip_q       <= '0;
            inflight_q <= '0;
            irq_prev_q <= '0;
            irq_out_q  <= '0;
            for (int i = 0; i < NUM_IRQ; i++) begin
                cnt_q[i] <= '0;
            end
            for (int t = 0; t < NUM_TGT; t++) begin
                best_id_q[t] <= '0;
            end
        end else begin
            ip_q       <= ip_d;
            inflight_q <= inflight_d;
            irq_prev_q <= bus.irq_i;
            irq_out_q  <= irq_out_d;
            for (int i = 0; i < NUM_IRQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            for (int t = 0; t < NUM_TGT; t++) begin
                best_id_q[t] <= best_id_d[t];
            end
        end
    end

    assign bus.ip_o  = ip_q;
    assign bus.id_o  = id_o_c;
    assign bus.irq_o = irq_out_q;

endmodule
